empty_ptr_storage: RTL and testbench
====================================

Name: empty_ptr_storage

Overview:
- Free-list of data-table addresses. Supplies the insert engine with the next unused data RAM address (empty_addr_i / empty_addr_val_i / empty_addr_rd_ack_o on the insert side).
- Takes back addresses released by the delete engine.
- After reset it self-initialises with every address 0..2^A_WIDTH-1, then runs as a circular FIFO with a two-entry prefetch so the head address is always presented registered and stable.

Parameters:
A_WIDTH, TABLE_ADDR_WIDTH, data-table address width; depth = 2^A_WIDTH entries

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
add_addr_i  in  A_WIDTH  address freed by delete engine
add_addr_val_i  in  1  push strobe, one address per cycle
next_empty_addr_o  out  A_WIDTH  head free address, to insert empty_addr_i
next_empty_addr_val_o  out  1  head valid, to insert empty_addr_val_i
next_empty_addr_rd_ack_i  in  1  pop strobe, from insert empty_addr_rd_ack_o
empty_cnt_o  out  A_WIDTH+1  free addresses held (RAM + prefetch)
init_done_o  out  1  initial fill complete
overflow_o  out  1  sticky: push dropped (full or during init)
underflow_o  out  1  sticky: pop with val_o=0

Behaviour:
- Reset values: all outputs 0; FSM=INIT_S; init counter, wr_ptr, rd_ptr=0; prefetch empty.
- Storage: simple dual-port RAM, 2^A_WIDTH x A_WIDTH, 1-cycle registered read. Two-entry prefetch register pair at the output. Head entry drives next_empty_addr_o; val_o = head entry valid.
- FSM INIT_S:
  - Writes init_cnt into RAM[init_cnt] each cycle; init_cnt and empty_cnt_o increment.
  - At init_cnt = 2^A_WIDTH-1 (last write), go to WORK_S. init_done_o=1 from the next cycle.
  - wr_ptr wraps to 0. RAM holds 2^A entries. empty_cnt_o = 2^A_WIDTH.
  - val_o=0 throughout; pushes dropped and overflow_o set; pops ignored and underflow_o set.
- FSM WORK_S (no exit except reset):
  - Push: RAM[wr_ptr] <= add_addr_i, wr_ptr++ mod 2^A, empty_cnt_o++. If empty_cnt_o = 2^A_WIDTH, drop and set overflow_o; counters unchanged.
  - Pop (rd_ack with val_o=1): head <= second prefetch entry; empty_cnt_o--.
  - Pop with val_o=0: ignored, set underflow_o.
  - Prefetch refill: issue RAM read at rd_ptr (rd_ptr++) when RAM occupancy > 0 and (prefetch valid + reads in flight - pop this cycle) < 2. Data lands in the first free prefetch slot next cycle.
  - Sustains one pop per cycle while RAM is non-empty.
  - Same-cycle push+pop: both take effect; empty_cnt_o unchanged.
- Latency:
  - Pop with >=2 held: new head valid the next cycle. val_o never drops between pops in this case (insert IDLE relies on this).
  - Push into a fully empty store: val_o=1 on the 2nd cycle after push (write, read, prefetch).
- Stability: next_empty_addr_o / val_o change only on pop or on prefetch fill of an empty head. The insert engine may sample the head over several cycles before acking.
- Read-during-write on the same RAM address cannot occur: occupancy gating keeps rd_ptr != wr_ptr whenever a read is issued for unwritten data.
- Reset mid-operation: immediate return to INIT_S, full re-fill. In-flight reads discarded, sticky flags cleared.

Decomposition:
- hash_table package: TABLE_ADDR_WIDTH (existing); new typedef empty_ptr_t = logic [TABLE_ADDR_WIDTH-1:0].
- Sub-module: the RAM as a generic simple_dual_port_ram (1-cycle read, no reset) reused by head/data tables.
- FSM, pointers, counter and prefetch stay in empty_ptr_storage.

Test Plan:
- A_WIDTH=4, reset released -> init_done_o=1 after 16 cycles; val_o=1 within 2 further cycles; addr=0; empty_cnt_o=16.
- Pops on 4 consecutive cycles -> addresses 0,1,2,3; val_o stays 1; empty_cnt_o=12.
- Pop all 16, then push 0x5 -> val_o=0, underflow_o=0, cnt=0 before the push; val_o=1 with addr=0x5 two cycles after push; cnt=1.
- Push while cnt=16 -> overflow_o=1; cnt stays 16; FIFO order is unchanged (next pop still returns 0).
- Simultaneous push 0xA and pop at cnt=1 (head 0x5) -> cnt stays 1; next head 0xA within 2 cycles; no underflow.
- rst_i pulsed mid-stream after 7 pops -> cnt=0, flags 0, init_done_o=0; re-init completes; first pop returns 0.

Source files
------------

// File: rtl/hash_table_pkg.sv
// Shared types and constants for the hash table: table address width,
// free-list pointer type and free-list FSM encodings.
package hash_table_pkg;

  localparam int unsigned TABLE_ADDR_WIDTH = 4;

  typedef logic [TABLE_ADDR_WIDTH-1:0] empty_ptr_t;

  localparam logic [0:0] INIT_S = 1'b0;
  localparam logic [0:0] WORK_S = 1'b1;

endpackage

// File: rtl/simple_dual_port_ram.sv
// Generic simple dual-port RAM: one write port, one read port with a
// registered (1-cycle) read. No reset on the array or the read register.
module simple_dual_port_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/empty_ptr_storage.sv
// Free-list of data-table addresses: self-fills with 0..2^A_WIDTH-1 after reset,
// then runs as a circular FIFO with a two-entry prefetch holding a stable head.
module empty_ptr_storage
  import hash_table_pkg::*;
#(
  parameter int unsigned A_WIDTH = TABLE_ADDR_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [A_WIDTH-1:0] add_addr_i,
  input  logic               add_addr_val_i,
  output logic [A_WIDTH-1:0] next_empty_addr_o,
  output logic               next_empty_addr_val_o,
  input  logic               next_empty_addr_rd_ack_i,
  output logic [A_WIDTH:0]   empty_cnt_o,
  output logic               init_done_o,
  output logic               overflow_o,
  output logic               underflow_o
);

  localparam int unsigned DEPTH = 2 ** A_WIDTH;
  localparam int unsigned CW    = A_WIDTH + 1;
  localparam logic [CW-1:0]      FULL_CNT = CW'(DEPTH);
  localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(DEPTH - 1);

  logic [0:0]         state_q,    state_d;
  logic [A_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [A_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
  logic [A_WIDTH-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]      ram_cnt_q,  ram_cnt_d;
  logic [CW-1:0]      cnt_q,      cnt_d;
  logic [A_WIDTH-1:0] head_q,     head_d;
  logic [A_WIDTH-1:0] nxt_q,      nxt_d;
  logic               head_val_q, head_val_d;
  logic               nxt_val_q,  nxt_val_d;
  logic               rd_pend_q,  rd_pend_d;
  logic               done_q,     done_d;
  logic               ovf_q,      ovf_d;
  logic               unf_q,      unf_d;

  logic               ram_we;
  logic [A_WIDTH-1:0] ram_waddr;
  logic [A_WIDTH-1:0] ram_wdata;
  logic               ram_re;
  logic [A_WIDTH-1:0] ram_rdata;
  logic               push_ok;
  logic               pop_ok;
  logic [1:0]         pf_level;

  simple_dual_port_ram #(
    .DATA_WIDTH (A_WIDTH),
    .ADDR_WIDTH (A_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= INIT_S;
      init_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      nxt_q      <= '0;
      head_val_q <= 1'b0;
      nxt_val_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      nxt_q      <= nxt_d;
      head_val_q <= head_val_d;
      nxt_val_q  <= nxt_val_d;
      rd_pend_q  <= rd_pend_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Next-state, RAM control, prefetch shift/fill
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    cnt_d      = cnt_q;
    head_d     = head_q;
    nxt_d      = nxt_q;
    head_val_d = head_val_q;
    nxt_val_d  = nxt_val_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_ptr_q;
    ram_wdata  = add_addr_i;
    ram_re     = 1'b0;
    push_ok    = 1'b0;
    pop_ok     = 1'b0;
    pf_level   = 2'd0;

    case (state_q)
      INIT_S: begin
        ram_we     = 1'b1;
        ram_waddr  = init_cnt_q;
        ram_wdata  = init_cnt_q;
        init_cnt_d = init_cnt_q + A_WIDTH'(1);
        ram_cnt_d  = ram_cnt_q + CW'(1);
        cnt_d      = cnt_q + CW'(1);
        if (add_addr_val_i) ovf_d = 1'b1;
        if (next_empty_addr_rd_ack_i) unf_d = 1'b1;
        if (init_cnt_q == LAST_IDX) begin
          state_d = WORK_S;
          done_d  = 1'b1;
        end
      end
      default: begin
        push_ok = add_addr_val_i && (cnt_q != FULL_CNT);
        pop_ok  = next_empty_addr_rd_ack_i && head_val_q;
        if (add_addr_val_i && !push_ok) ovf_d = 1'b1;
        if (next_empty_addr_rd_ack_i && !head_val_q) unf_d = 1'b1;

        // Count held + in-flight entries net of this pop; keep at most two
        pf_level = 2'(head_val_q) + 2'(nxt_val_q) + 2'(rd_pend_q) - 2'(pop_ok);
        ram_re   = (ram_cnt_q != '0) && (pf_level < 2'd2);
        ram_we   = push_ok;

        if (push_ok) wr_ptr_d = wr_ptr_q + A_WIDTH'(1);
        if (ram_re)  rd_ptr_d = rd_ptr_q + A_WIDTH'(1);
        ram_cnt_d = ram_cnt_q + CW'(push_ok) - CW'(ram_re);
        cnt_d     = cnt_q + CW'(push_ok) - CW'(pop_ok);

        if (pop_ok) begin
          head_d     = nxt_q;
          head_val_d = nxt_val_q;
          nxt_val_d  = 1'b0;
        end
        if (rd_pend_q) begin
          if (!head_val_d) begin
            head_d     = ram_rdata;
            head_val_d = 1'b1;
          end else begin
            nxt_d     = ram_rdata;
            nxt_val_d = 1'b1;
          end
        end
      end
    endcase

    rd_pend_d = ram_re;
  end

  assign next_empty_addr_o     = head_q;
  assign next_empty_addr_val_o = head_val_q;
  assign empty_cnt_o           = cnt_q;
  assign init_done_o           = done_q;
  assign overflow_o            = ovf_q;
  assign underflow_o           = unf_q;

endmodule

// File: tb/tb_empty_ptr_storage.sv
// Directed bench for empty_ptr_storage (A_WIDTH=4): init fill, pop order,
// drain/refill latency, overflow, simultaneous push+pop, mid-stream reset.
module tb_empty_ptr_storage;

  localparam int unsigned AW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] add_addr_i;
  logic          add_addr_val_i;
  logic [AW-1:0] next_empty_addr_o;
  logic          next_empty_addr_val_o;
  logic          next_empty_addr_rd_ack_i;
  logic [AW:0]   empty_cnt_o;
  logic          init_done_o;
  logic          overflow_o;
  logic          underflow_o;

  int total = 0;
  int bad   = 0;

  empty_ptr_storage #(.A_WIDTH(AW)) dut (
    .clk_i                    (clk_i),
    .rst_i                    (rst_i),
    .add_addr_i               (add_addr_i),
    .add_addr_val_i           (add_addr_val_i),
    .next_empty_addr_o        (next_empty_addr_o),
    .next_empty_addr_val_o    (next_empty_addr_val_o),
    .next_empty_addr_rd_ack_i (next_empty_addr_rd_ack_i),
    .empty_cnt_o              (empty_cnt_o),
    .init_done_o              (init_done_o),
    .overflow_o               (overflow_o),
    .underflow_o              (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Tick until init_done_o rises (bounded); edges = edges taken, 0 on timeout.
  task automatic wait_init(output int edges);
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (init_done_o) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    add_addr_i = '0;
    add_addr_val_i = 1'b0;
    next_empty_addr_rd_ack_i = 1'b0;
    repeat (3) tick();
    total++;
    if ({init_done_o, next_empty_addr_val_o, overflow_o, underflow_o} !== 4'b0000 ||
        empty_cnt_o !== 5'd0 || next_empty_addr_o !== 4'h0) begin
      bad++;
      $display("FAIL reset_outputs: done=%b val=%b ovf=%b unf=%b cnt=%0d addr=%0h, want all 0",
               init_done_o, next_empty_addr_val_o, overflow_o, underflow_o, empty_cnt_o,
               next_empty_addr_o);
    end
    rst_i = 1'b0;
    repeat (15) tick();
    total++;
    if (init_done_o !== 1'b0 || empty_cnt_o !== 5'd15 || next_empty_addr_val_o !== 1'b0) begin
      bad++;
      $display("FAIL init_15: done=%b cnt=%0d val=%b, want 0 15 0",
               init_done_o, empty_cnt_o, next_empty_addr_val_o);
    end
    tick();
    total++;
    if (init_done_o !== 1'b1 || empty_cnt_o !== 5'd16) begin
      bad++;
      $display("FAIL init_16: done=%b cnt=%0d, want 1 16", init_done_o, empty_cnt_o);
    end
    tick();
    total++;
    if (next_empty_addr_val_o !== 1'b0) begin
      bad++;
      $display("FAIL head_not_yet: val=%b, want 0", next_empty_addr_val_o);
    end
    tick();
    total++;
    if (next_empty_addr_val_o !== 1'b1 || next_empty_addr_o !== 4'h0 || empty_cnt_o !== 5'd16) begin
      bad++;
      $display("FAIL first_head: val=%b addr=%0h cnt=%0d, want 1 0 16",
               next_empty_addr_val_o, next_empty_addr_o, empty_cnt_o);
    end
  endtask

  task automatic test_overflow();
    add_addr_i = 4'h9;
    add_addr_val_i = 1'b1;
    tick();
    add_addr_val_i = 1'b0;
    total++;
    if (overflow_o !== 1'b1 || empty_cnt_o !== 5'd16 || underflow_o !== 1'b0) begin
      bad++;
      $display("FAIL overflow_full: ovf=%b cnt=%0d unf=%b, want 1 16 0",
               overflow_o, empty_cnt_o, underflow_o);
    end
    tick();
    total++;
    if (next_empty_addr_o !== 4'h0 || next_empty_addr_val_o !== 1'b1) begin
      bad++;
      $display("FAIL overflow_head: addr=%0h val=%b, want 0 1",
               next_empty_addr_o, next_empty_addr_val_o);
    end
  endtask

  task automatic test_pops();
    next_empty_addr_rd_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (next_empty_addr_val_o !== 1'b1 || next_empty_addr_o !== AW'(i)) begin
        bad++;
        $display("FAIL pop_%0d: val=%b addr=%0h, want 1 %0h", i,
                 next_empty_addr_val_o, next_empty_addr_o, i);
      end
      tick();
    end
    next_empty_addr_rd_ack_i = 1'b0;
    total++;
    if (empty_cnt_o !== 5'd12 || next_empty_addr_val_o !== 1'b1 || next_empty_addr_o !== 4'h4) begin
      bad++;
      $display("FAIL after_4_pops: cnt=%0d val=%b addr=%0h, want 12 1 4",
               empty_cnt_o, next_empty_addr_val_o, next_empty_addr_o);
    end
  endtask

  task automatic test_drain();
    next_empty_addr_rd_ack_i = 1'b1;
    for (int i = 4; i < 16; i++) begin
      total++;
      if (next_empty_addr_val_o !== 1'b1 || next_empty_addr_o !== AW'(i)) begin
        bad++;
        $display("FAIL drain_%0d: val=%b addr=%0h, want 1 %0h", i,
                 next_empty_addr_val_o, next_empty_addr_o, i);
      end
      tick();
    end
    next_empty_addr_rd_ack_i = 1'b0;
    tick();
    total++;
    if (next_empty_addr_val_o !== 1'b0 || empty_cnt_o !== 5'd0 || underflow_o !== 1'b0) begin
      bad++;
      $display("FAIL drained: val=%b cnt=%0d unf=%b, want 0 0 0",
               next_empty_addr_val_o, empty_cnt_o, underflow_o);
    end
  endtask

  // Push into an empty store: write edge, read edge, prefetch edge.
  task automatic test_push_empty();
    add_addr_i = 4'h5;
    add_addr_val_i = 1'b1;
    tick();
    add_addr_val_i = 1'b0;
    total++;
    if (next_empty_addr_val_o !== 1'b0 || empty_cnt_o !== 5'd1) begin
      bad++;
      $display("FAIL push_write: val=%b cnt=%0d, want 0 1", next_empty_addr_val_o, empty_cnt_o);
    end
    tick();
    tick();
    total++;
    if (next_empty_addr_val_o !== 1'b1 || next_empty_addr_o !== 4'h5 || empty_cnt_o !== 5'd1) begin
      bad++;
      $display("FAIL push_head: val=%b addr=%0h cnt=%0d, want 1 5 1",
               next_empty_addr_val_o, next_empty_addr_o, empty_cnt_o);
    end
  endtask

  task automatic test_push_pop();
    add_addr_i = 4'hA;
    add_addr_val_i = 1'b1;
    next_empty_addr_rd_ack_i = 1'b1;
    tick();
    add_addr_val_i = 1'b0;
    next_empty_addr_rd_ack_i = 1'b0;
    total++;
    if (empty_cnt_o !== 5'd1 || underflow_o !== 1'b0 || overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL push_pop_cnt: cnt=%0d unf=%b ovf=%b, want 1 0 1",
               empty_cnt_o, underflow_o, overflow_o);
    end
    tick();
    tick();
    total++;
    if (next_empty_addr_val_o !== 1'b1 || next_empty_addr_o !== 4'hA) begin
      bad++;
      $display("FAIL push_pop_head: val=%b addr=%0h, want 1 a",
               next_empty_addr_val_o, next_empty_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    // Push and pop during init: both rejected, fill continues
    add_addr_val_i = 1'b1;
    next_empty_addr_rd_ack_i = 1'b1;
    tick();
    add_addr_val_i = 1'b0;
    next_empty_addr_rd_ack_i = 1'b0;
    total++;
    if (overflow_o !== 1'b1 || underflow_o !== 1'b1 || empty_cnt_o !== 5'd1 ||
        next_empty_addr_val_o !== 1'b0) begin
      bad++;
      $display("FAIL init_reject: ovf=%b unf=%b cnt=%0d val=%b, want 1 1 1 0",
               overflow_o, underflow_o, empty_cnt_o, next_empty_addr_val_o);
    end
    wait_init(edges);
    total++;
    if (edges !== 15) begin
      bad++;
      $display("FAIL reinit_len: edges=%0d, want 15 more", edges);
    end
    repeat (2) tick();
    next_empty_addr_rd_ack_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (next_empty_addr_val_o !== 1'b1 || next_empty_addr_o !== AW'(i)) begin
        bad++;
        $display("FAIL mid_pop_%0d: val=%b addr=%0h, want 1 %0h", i,
                 next_empty_addr_val_o, next_empty_addr_o, i);
      end
      tick();
    end
    next_empty_addr_rd_ack_i = 1'b0;
    // Asynchronous reset takes effect without a clock edge
    #1 rst_i = 1'b1;
    #1;
    total++;
    if (empty_cnt_o !== 5'd0 || {init_done_o, overflow_o, underflow_o, next_empty_addr_val_o} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset: cnt=%0d done=%b ovf=%b unf=%b val=%b, want 0 0 0 0 0",
               empty_cnt_o, init_done_o, overflow_o, underflow_o, next_empty_addr_val_o);
    end
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    wait_init(edges);
    total++;
    if (edges !== 16 || empty_cnt_o !== 5'd16) begin
      bad++;
      $display("FAIL refill: edges=%0d cnt=%0d, want 16 16", edges, empty_cnt_o);
    end
    repeat (2) tick();
    total++;
    if (next_empty_addr_val_o !== 1'b1 || next_empty_addr_o !== 4'h0) begin
      bad++;
      $display("FAIL refill_head: val=%b addr=%0h, want 1 0",
               next_empty_addr_val_o, next_empty_addr_o);
    end
    next_empty_addr_rd_ack_i = 1'b1;
    tick();
    next_empty_addr_rd_ack_i = 1'b0;
    total++;
    if (next_empty_addr_o !== 4'h1 || empty_cnt_o !== 5'd15) begin
      bad++;
      $display("FAIL refill_pop: addr=%0h cnt=%0d, want 1 15", next_empty_addr_o, empty_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_pops();
    test_drain();
    test_push_empty();
    test_push_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
